shift_tx_sequencer: RTL and testbench
=====================================

// Module: shift_tx_sequencer
// PURPOSE
//  Upstream control stage for uni_shift_register. Accepts parallel words over valid/ready,
//  drives the register's select/in/serial inputs to load then shift WIDTH bits out, and
//  presents the exiting bit as a serial stream with valid/ready backpressure.
//  Sits between a word producer and the universal shift register.
// PARAMETERS
//  WIDTH  4  data word width; must match uni_shift_register width (>=2)
//  FILL   0  value driven on both serial inputs while shifting (vacated bits)
// PORTS
//  clk              in   1      clock, rising edge
//  clear            in   1      asynchronous, active-low reset; shared with uni_shift_register
//  in_data          in   WIDTH  parallel word to transmit
//  in_msb_first     in   1      1: MSB first (shift left), 0: LSB first (shift right)
//  in_valid         in   1      word offered
//  in_ready         out  1      word accepted when in_valid && in_ready
//  sr_select        out  2      to register select: 00 hold, 01 shift right, 10 shift left, 11 load
//  sr_in            out  WIDTH  to register parallel input
//  sr_serial_right  out  1      to register serial_in_right (=FILL)
//  sr_serial_left   out  1      to register serial_in_left (=FILL)
//  sr_out           in   WIDTH  from register out
//  tx_bit           out  1      current serial bit
//  tx_valid         out  1      tx_bit valid
//  tx_ready         in   1      consumer accepts tx_bit when tx_valid && tx_ready
//  tx_last          out  1      final bit of the frame
//  busy             out  1      frame in progress (state != IDLE)
// BEHAVIOUR
//  - Register semantics: shift right out<={serial_in_right,out[W-1:1]}, exit bit out[0];
//    shift left out<={out[W-2:0],serial_in_left}, exit bit out[W-1].
//  - Reset (clear=0, async): state IDLE, bit count 0, word/dir regs 0; sr_select=00, sr_in=0,
//    tx_valid=0, tx_last=0, busy=0, in_ready=0 while clear low; in_ready=1 first cycle after release.
//  - FSM IDLE -> LOAD -> SHIFT -> [PARITY] -> IDLE.
//  - IDLE: in_ready=1, sr_select=00. Accept: latch in_data, in_msb_first; -> LOAD.
//  - LOAD (1 cycle): sr_select=11, sr_in=latched word; in_ready=0, tx_valid=0; -> SHIFT, count=0.
//  - SHIFT: tx_valid=1, tx_bit=sr_out[0] (LSB-first) or sr_out[WIDTH-1] (MSB-first).
//    tx_ready=1: sr_select=01/10 per dir, count++; tx_ready=0: sr_select=00, count held, tx_bit stable.
//    tx_last=1 when count==WIDTH-1 (no parity). Accept at count==WIDTH-1 -> next state (IDLE or PARITY).
//  - Latency: accept in cycle N, tx_valid first high cycle N+2; with tx_ready held 1, one bit/cycle,
//    in_ready high again cycle N+2+WIDTH (no back-to-back overlap; one idle accept cycle per frame).
//  - in_valid while busy: ignored, no state change; producer holds word until accepted.
//  - sr_in holds latched word in all states (only sampled during LOAD).
//  - Reset mid-frame: immediate abort to reset values; partial frame discarded, no tx_last.
//  - Counter width $clog2(WIDTH); no wrap beyond WIDTH-1.
// CONFIGURATION
//  SHIFT_TX_PARITY_EN defined: PARITY state after last data bit; tx_valid=1, tx_bit=even
//   parity (^word latched at accept), tx_last=1, sr_select=00; accept -> IDLE; frame=WIDTH+1 bits,
//   tx_last not asserted on final data bit.
//  Undefined: no PARITY state; frame=WIDTH bits; tx_last on final data bit.
// STRUCTURE
//  shift_pkg: select codes SEL_HOLD=2'b00, SEL_SHR=2'b01, SEL_SHL=2'b10, SEL_LOAD=2'b11;
//   state encodings ST_IDLE, ST_LOAD, ST_SHIFT, ST_PARITY. Shared with uni_shift_register and benches.
//  One sub-module: shift_bit_counter (clear/enable/terminal-count at WIDTH-1).
//  Bench instantiates shift_tx_sequencer + uni_shift_register with common clk/clear.
// TESTING (WIDTH=4, FILL=0)
//  1 Reset: clear=0 mid-idle -> sr_select=00, tx_valid=0, busy=0, in_ready=0; release -> in_ready=1.
//  2 LSB-first 4'b1101, tx_ready=1 -> select 11,01,01,01,01; tx_bit 1,0,1,1; tx_last on 4th; in_ready next cycle.
//  3 MSB-first 4'b1101, tx_ready=1 -> select 11 then 10 x4; tx_bit 1,1,0,1; register out ends 4'b0000.
//  4 Backpressure: LSB-first 4'b0110, tx_ready=0 for 3 cycles at 2nd bit -> tx_bit held 1, select=00; bits 0,1,1,0 intact.
//  5 Reset mid-frame after 2 bits of 4'b1010 -> tx_valid=0 at once, busy=0; next word 4'b0011 sent cleanly 1,1,0,0.
//  6 SHIFT_TX_PARITY_EN, LSB-first 4'b1101 -> bits 1,0,1,1 then parity 1 with tx_last; 4'b1001 -> parity 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared select codes and sequencer states for the shift-register transmit path.
package shift_pkg;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_SHR  = 2'b01,
        SEL_SHL  = 2'b10,
        SEL_LOAD = 2'b11
    } sel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_SHIFT  = 2'b10,
        ST_PARITY = 2'b11
    } state_t;

    function automatic sel_t shift_sel(input logic msb_first);
        return msb_first ? SEL_SHL : SEL_SHR;
    endfunction

endpackage

// File: rtl/shift_tx_sequencer_if.sv
// Word-in / bit-out handshake bundle between producer, sequencer and serial consumer.
interface shift_tx_sequencer_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] in_data;
    logic             in_msb_first;
    logic             in_valid;
    logic             in_ready;
    logic             tx_bit;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;

    modport master (
        input  in_data, in_msb_first, in_valid, tx_ready,
        output in_ready, tx_bit, tx_valid, tx_last
    );

    modport slave (
        output in_data, in_msb_first, in_valid, tx_ready,
        input  in_ready, tx_bit, tx_valid, tx_last
    );
endinterface

// File: rtl/shift_bit_counter.sv
// Bit-position counter for a frame; saturates at WIDTH-1 and flags terminal count.
module shift_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic zero,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            count <= '0;
        end else if (zero) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == LAST);
endmodule

// File: rtl/uni_shift_register.sv
// Universal shift register: hold, shift right, shift left, parallel load.
module uni_shift_register
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] par_in,
    input  logic             serial_in_right,
    input  logic             serial_in_left,
    output logic [WIDTH-1:0] out
);
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            out <= '0;
        end else begin
            unique case (select)
                SEL_SHR:  out <= {serial_in_right, out[WIDTH-1:1]};
                SEL_SHL:  out <= {out[WIDTH-2:0], serial_in_left};
                SEL_LOAD: out <= par_in;
                default:  out <= out;
            endcase
        end
    end
endmodule

// File: rtl/shift_tx_sequencer.sv
// Loads a parallel word into uni_shift_register and streams it out bit by bit.
// Optional even-parity trailer bit when SHIFT_TX_PARITY_EN is defined.
module shift_tx_sequencer
    import shift_pkg::*;
#(
    parameter int   WIDTH = 4,
    parameter logic FILL  = 1'b0
) (
    input  logic                  clk,
    input  logic                  clear,
    shift_tx_sequencer_if.master  bus,
    output logic [1:0]            sr_select,
    output logic [WIDTH-1:0]      sr_in,
    output logic                  sr_serial_right,
    output logic                  sr_serial_left,
    input  logic [WIDTH-1:0]      sr_out,
    output logic                  busy
);
    state_t           state;
    logic [WIDTH-1:0] word;
    logic             dir;
    logic             in_ready_q;
    logic             tx_valid_q;
    logic             busy_q;
    logic             tc;
    logic             unused_sr_out;
`ifdef SHIFT_TX_PARITY_EN
    logic             parity;
`endif

    shift_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .clear (clear),
        .zero  (state == ST_LOAD),
        .en    ((state == ST_SHIFT) && bus.tx_ready),
        .tc    (tc)
    );

    // Handshake flags are registered alongside the state they describe.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state      <= ST_IDLE;
            word       <= '0;
            dir        <= 1'b0;
            in_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        word       <= bus.in_data;
                        dir        <= bus.in_msb_first;
`ifdef SHIFT_TX_PARITY_EN
                        parity     <= ^bus.in_data;
`endif
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    tx_valid_q <= 1'b1;
                    state      <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bus.tx_ready && tc) begin
`ifdef SHIFT_TX_PARITY_EN
                        state      <= ST_PARITY;
`else
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        state      <= ST_IDLE;
`endif
                    end
                end
                ST_PARITY: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register control follows tx_ready in the same cycle so a stalled bit stays put.
    always_comb begin
        sr_select   = SEL_HOLD;
        bus.tx_bit  = 1'b0;
        bus.tx_last = 1'b0;
        unique case (state)
            ST_LOAD:  sr_select = SEL_LOAD;
            ST_SHIFT: begin
                sr_select  = bus.tx_ready ? shift_sel(dir) : SEL_HOLD;
                bus.tx_bit = dir ? sr_out[WIDTH-1] : sr_out[0];
`ifndef SHIFT_TX_PARITY_EN
                bus.tx_last = tc;
`endif
            end
`ifdef SHIFT_TX_PARITY_EN
            ST_PARITY: begin
                bus.tx_bit  = parity;
                bus.tx_last = 1'b1;
            end
`endif
            default: sr_select = SEL_HOLD;
        endcase
    end

    assign sr_in           = word;
    assign sr_serial_right = FILL;
    assign sr_serial_left  = FILL;
    assign bus.in_ready    = in_ready_q;
    assign bus.tx_valid    = tx_valid_q;
    assign busy            = busy_q;
    assign unused_sr_out   = ^{1'b0, sr_out};
endmodule

// File: tb/tb_shift_tx_sequencer.sv
// Directed bench: sequencer driving a real uni_shift_register, WIDTH=4, FILL=0.
module tb_shift_tx_sequencer;
    import shift_pkg::*;

`ifdef SHIFT_TX_PARITY_EN
    localparam int   NB  = 5;
    localparam logic LD  = 1'b0;
`else
    localparam int   NB  = 4;
    localparam logic LD  = 1'b1;
`endif

    logic       clk;
    logic       clear;
    logic [1:0] sr_select;
    logic [3:0] sr_in;
    logic       sr_serial_right;
    logic       sr_serial_left;
    logic [3:0] sr_out;
    logic       busy;

    shift_tx_sequencer_if #(.WIDTH(4)) bus ();

    shift_tx_sequencer #(.WIDTH(4), .FILL(1'b0)) dut (
        .clk             (clk),
        .clear           (clear),
        .bus             (bus),
        .sr_select       (sr_select),
        .sr_in           (sr_in),
        .sr_serial_right (sr_serial_right),
        .sr_serial_left  (sr_serial_left),
        .sr_out          (sr_out),
        .busy            (busy)
    );

    uni_shift_register #(.WIDTH(4)) u_sr (
        .clk             (clk),
        .clear           (clear),
        .select          (sr_select),
        .par_in          (sr_in),
        .serial_in_right (sr_serial_right),
        .serial_in_left  (sr_serial_left),
        .out             (sr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       m;
        logic       tr;
        logic [1:0] sel;
        logic       rdy;
        logic       vld;
        logic       b;
        logic       last;
        logic       bsy;
        logic       chk;
        logic [3:0] out;
    } vec_t;

    vec_t tbl[$];
    int   nchk = 0;
    int   nmis = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [3:0] d, input logic m, input logic tr,
                       input logic [1:0] sel, input logic rdy, input logic vld, input logic b,
                       input logic last, input logic bsy, input logic chk, input logic [3:0] out);
        tbl.push_back('{iv, d, m, tr, sel, rdy, vld, b, last, bsy, chk, out});
    endtask

    // Sends one word with tx_ready held high; exp_bits[k] is the k-th bit on the wire.
    task automatic run_frame(input logic [3:0] d, input logic m, input logic [4:0] exp_bits,
                             input string tag);
        int k;
        int cyc;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_msb_first = m; bus.tx_ready = 1'b1;
        #2 check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        k = 0;
        cyc = 0;
        while (k < NB && cyc < 12) begin
            #2;
            if (bus.tx_valid) begin
                check($sformatf("%s_bit%0d", tag, k), 32'(bus.tx_bit), 32'(exp_bits[k]));
                check($sformatf("%s_last%0d", tag, k), 32'(bus.tx_last), 32'(k == NB - 1));
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        if (k < NB) check({tag, "_timeout"}, 32'(k), 32'(NB));
        #2 check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_msb_first = 1'b0; bus.tx_ready = 1'b0;

        // LSB-first 1101, full speed
        add(1, 4'b1101, 0, 1, 2'b00, 1, 0, 0, 0, 0, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b11, 0, 0, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b01, 0, 1, 1, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b01, 0, 1, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b01, 0, 1, 1, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b01, 0, 1, 1, LD, 1, 0, 4'b0000);
`ifdef SHIFT_TX_PARITY_EN
        add(0, 4'b0000, 0, 1, 2'b00, 0, 1, 1, 1, 1, 0, 4'b0000);
`endif
        // MSB-first 1101
        add(1, 4'b1101, 1, 1, 2'b00, 1, 0, 0, 0, 0, 1, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b11, 0, 0, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b10, 0, 1, 1, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b10, 0, 1, 1, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b10, 0, 1, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b10, 0, 1, 1, LD, 1, 0, 4'b0000);
`ifdef SHIFT_TX_PARITY_EN
        add(0, 4'b0000, 0, 1, 2'b00, 0, 1, 1, 1, 1, 0, 4'b0000);
`endif
        // LSB-first 0110 with a 3-cycle stall on the 2nd bit; a busy-time offer is ignored
        add(1, 4'b0110, 0, 1, 2'b00, 1, 0, 0, 0, 0, 1, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b11, 0, 0, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b01, 0, 1, 0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 0, 2'b00, 0, 1, 1, 0, 1, 1, 4'b0011);
        add(1, 4'b1111, 0, 0, 2'b00, 0, 1, 1, 0, 1, 1, 4'b0011);
        add(1, 4'b1111, 0, 0, 2'b00, 0, 1, 1, 0, 1, 1, 4'b0011);
        add(0, 4'b0000, 0, 1, 2'b01, 0, 1, 1, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b01, 0, 1, 1, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 0, 1, 2'b01, 0, 1, 0, LD, 1, 0, 4'b0000);
`ifdef SHIFT_TX_PARITY_EN
        add(0, 4'b0000, 0, 1, 2'b00, 0, 1, 0, 1, 1, 0, 4'b0000);
`endif
        add(0, 4'b0000, 0, 1, 2'b00, 1, 0, 0, 0, 0, 1, 4'b0000);

        // Reset state, then release
        @(negedge clk);
        @(negedge clk);
        #2;
        check("rst_sel",      32'(sr_select),    32'd0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset asserted while idle
        @(negedge clk);
        clear = 1'b0;
        #2 check("idle_rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 check("idle_rel_in_ready", 32'(bus.in_ready), 32'd1);

        foreach (tbl[i]) begin
            @(negedge clk);
            bus.in_valid = tbl[i].iv; bus.in_data = tbl[i].d;
            bus.in_msb_first = tbl[i].m; bus.tx_ready = tbl[i].tr;
            #2;
            check($sformatf("row%0d_sel", i),      32'(sr_select),    32'(tbl[i].sel));
            check($sformatf("row%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].rdy));
            check($sformatf("row%0d_tx_valid", i), 32'(bus.tx_valid), 32'(tbl[i].vld));
            check($sformatf("row%0d_tx_last", i),  32'(bus.tx_last),  32'(tbl[i].last));
            check($sformatf("row%0d_busy", i),     32'(busy),         32'(tbl[i].bsy));
            if (tbl[i].vld)
                check($sformatf("row%0d_tx_bit", i), 32'(bus.tx_bit), 32'(tbl[i].b));
            if (tbl[i].chk)
                check($sformatf("row%0d_sr_out", i), 32'(sr_out), 32'(tbl[i].out));
        end

        // Abort after two bits of 1010, then a clean frame
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 4'b1010; bus.in_msb_first = 1'b0; bus.tx_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        #2 check("abort_bit0", 32'(bus.tx_bit), 32'd0);
        @(negedge clk);
        #2 check("abort_bit1", 32'(bus.tx_bit), 32'd1);
        @(negedge clk);
        clear = 1'b0;
        #2;
        check("abort_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("abort_busy",     32'(busy),         32'd0);
        check("abort_tx_last",  32'(bus.tx_last),  32'd0);
        check("abort_sel",      32'(sr_select),    32'd0);
        check("abort_sr_out",   32'(sr_out),       32'd0);
        @(negedge clk);
        clear = 1'b1;
        run_frame(4'b0011, 1'b0, 5'b00011, "after_abort");

        // Parity 0 word; in the default build the 5th bit is not sent
        run_frame(4'b1001, 1'b0, 5'b01001, "w1001");
`ifdef SHIFT_TX_PARITY_EN
        run_frame(4'b1101, 1'b0, 5'b11101, "par1101");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nmis);
        $finish;
    end
endmodule
